mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-ported, fixed-latency unified memory between the fetch
//   stage (instruction reads) and the memory stage (data loads/stores).
//   Serialises accesses with an owner FSM and a latency counter. Drives
//   stall_f/stall_m so the pipeline holds until its access completes.
//   Data port has priority; a burst counter bounds fetch starvation.
// PARAMETERS
//   ADDR_W        32  address width, both ports and the memory
//   DATA_W        32  data width
//   MEM_LAT       2   memory read/write latency in cycles (legal 1..15)
//   MAX_DM_BURST  4   consecutive data grants allowed while if_req waits (1..15)
// PORTS
//   clk        in   1       clock, rising edge
//   rst        in   1       reset, asynchronous, active-low
//   if_req     in   1       fetch request; held with if_addr until if_done
//   if_addr    in   ADDR_W  fetch address
//   if_done    out  1       fetch complete; if_rdata valid this cycle
//   if_rdata   out  DATA_W  fetched instruction
//   dm_req     in   1       data request; held with dm_we/addr/wdata until dm_done
//   dm_we      in   1       1 = store, 0 = load
//   dm_addr    in   ADDR_W  data address
//   dm_wdata   in   DATA_W  store data
//   dm_done    out  1       data access complete; dm_rdata valid this cycle (loads)
//   dm_rdata   out  DATA_W  load data
//   mem_en     out  1       memory access active
//   mem_we     out  1       memory write enable
//   mem_addr   out  ADDR_W  memory address
//   mem_wdata  out  DATA_W  memory write data
//   mem_rdata  in   DATA_W  memory read data, valid in last cycle of access
//   stall_f    out  1       if_req & ~if_done
//   stall_m    out  1       dm_req & ~dm_done
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, cnt=0, burst=0, latched addr/we/wdata=0.
//     All outputs 0. An in-flight access is aborted; no done pulse follows.
//   FSM states: IDLE, BUSY_IF, BUSY_DM. mem_en=1 only in BUSY_*.
//   IDLE grant rules, evaluated each cycle:
//     - dm_req & ~(if_req & burst==MAX_DM_BURST) -> BUSY_DM
//     - else if_req -> BUSY_IF
//     - else stay in IDLE
//   On grant: latch port addr/we/wdata and load cnt=MEM_LAT-1.
//     Fetch grants latch we=0, wdata=0.
//     mem_addr/mem_we/mem_wdata come from the latched registers only.
//     Requester input changes after grant have no effect.
//   BUSY_*: cnt decrements each cycle. When cnt==0:
//     - Owner's done=1 combinationally that cycle.
//     - Owner's rdata = mem_rdata combinationally (dm_rdata also for stores;
//       value is don't-care for stores).
//     - Next state = IDLE.
//     Non-owner's done=0 and rdata=0.
//   Latency: request seen in IDLE at cycle t -> BUSY cycles t+1..t+MEM_LAT ->
//     done at t+MEM_LAT. At least one IDLE cycle between transactions.
//   Burst counter:
//     - DM grant while if_req=1: burst <- burst+1, saturating at MAX_DM_BURST.
//     - IF grant, or any IDLE cycle with if_req=0: burst <- 0.
//   Once granted, a transaction always completes. If req drops mid-access
//     (e.g. branch redirect), done still pulses and the requester ignores it.
//   Simultaneous if_req/dm_req in IDLE: DM wins unless burst limit reached.
//   stall_f/stall_m are combinational; both stalls may be 1 in the same cycle.
// TESTING
//   1. MEM_LAT=2, if_req=1, if_addr=0x10 at t0 -> mem_en=1, mem_addr=0x10,
//      mem_we=0 at t1..t2; if_done=1 at t2 with if_rdata=mem_rdata; stall_f=0 at t2.
//   2. if_req and dm_req (load 0x200) together at t0 -> DM served t1..t2,
//      dm_done at t2; IDLE t3; IF served t4..t5, if_done at t5; stall_f=1 t0..t4.
//   3. Store dm_we=1, addr=0x40, wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF
//      for both BUSY cycles; dm_done pulses once; if_done stays 0.
//   4. MAX_DM_BURST=2; dm_req held back-to-back with new addresses, if_req held
//      -> exactly 2 DM grants, then IF granted, then burst=0 and DM resumes.
//   5. rst=0 during the 1st BUSY cycle of a fetch -> all outputs 0 immediately;
//      no if_done afterwards; after release, a re-issued request is served normally.
//   6. MEM_LAT=1; if_addr changed after grant -> mem_addr keeps the granted
//      address; done is asserted in the single BUSY cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-ported memory between fetch and data ports
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LAT      = 2,
   parameter int MAX_DM_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_done,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_f,
   output logic              stall_m
);
   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

   localparam logic [3:0] CNT_INIT  = 4'(MEM_LAT - 1);
   localparam logic [3:0] BURST_MAX = 4'(MAX_DM_BURST);

   state_t            r_state;
   state_t            w_next;
   logic [3:0]        r_cnt;
   logic [3:0]        r_burst;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic [DATA_W-1:0] r_wdata;
   logic              w_grant_dm;
   logic              w_grant_if;
   logic              w_fin;

   assign w_fin = (r_state != IDLE) && (r_cnt == 4'd0);

   // grant arbitration in IDLE (data first unless fetch has waited a full burst); release when the access ends
   always_comb begin
      w_grant_dm = 1'b0;
      w_grant_if = 1'b0;
      w_next     = r_state;
      if (r_state == IDLE) begin
         w_grant_dm = dm_req && !(if_req && r_burst == BURST_MAX);
         w_grant_if = !w_grant_dm && if_req;
         w_next     = w_grant_dm ? BUSY_DM : (w_grant_if ? BUSY_IF : IDLE);
      end else if (w_fin) begin
         w_next = IDLE;
      end
   end

   // owner state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   // latency counter: loaded on grant, counts down to the completing cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                         r_cnt <= 4'd0;
      else if (w_grant_dm || w_grant_if) r_cnt <= CNT_INIT;
      else if (r_cnt != 4'd0)           r_cnt <= r_cnt - 4'd1;
   end

   // consecutive data grants taken while fetch waits; cleared whenever fetch is served or not asking
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  r_burst <= 4'd0;
      else if (r_state == IDLE)  r_burst <= (w_grant_dm && if_req)
                                            ? ((r_burst == BURST_MAX) ? r_burst : r_burst + 4'd1)
                                            : 4'd0;
   end

   // capture the winning request so later requester changes cannot disturb the access
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
      end else if (w_grant_dm) begin
         r_addr  <= dm_addr;
         r_we    <= dm_we;
         r_wdata <= dm_wdata;
      end else if (w_grant_if) begin
         r_addr  <= if_addr;
         r_we    <= 1'b0;
         r_wdata <= '0;
      end
   end

   assign mem_en    = (r_state != IDLE);
   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign if_done   = w_fin && (r_state == BUSY_IF);
   assign dm_done   = w_fin && (r_state == BUSY_DM);
   assign if_rdata  = if_done ? mem_rdata : '0;
   assign dm_rdata  = dm_done ? mem_rdata : '0;
   assign stall_f   = rst && if_req && !if_done;
   assign stall_m   = rst && dm_req && !dm_done;
endmodule
